// File: rtl/uart_tx_pkg.sv
// Shared encodings and constants for the UART transmit arbiter.
// Imported by the arbiter top; the FIFO is byte-wide and needs nothing from here.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // 11 bit-times (start, 8 data, parity, stop) at 16 clocks per bit
  localparam int UART_FRAME_CLKS = 176;

  localparam logic SRC_MAN = 1'b0;
  localparam logic SRC_SCR = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through output and a synchronous flush.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Merges the manual and scripted byte streams onto the single UART transmit input,
// one source at a time, spacing bytes by at least one UART frame.
//
//   state | meaning
//   IDLE  | may switch source, or pop the active FIFO head into tx_bits
//   SEND  | tx_valid pulse cycle; gap counter is loaded
//   GAP   | frame time elapsing; counts down to zero then back to IDLE
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = UART_FRAME_CLKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       src_sel,
  input  logic [7:0] man_bits,
  input  logic       man_valid,
  input  logic [7:0] scr_bits,
  input  logic       scr_valid,
  output logic [7:0] tx_bits,
  output logic       tx_valid,
  output logic       busy,
  output logic       man_overflow,
  output logic       scr_overflow
);

  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic          r_active;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_tx_bits;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_man_ovf;
  logic          r_scr_ovf;

  logic       w_man_push, w_man_pop, w_man_flush, w_man_empty, w_man_full, w_man_drop;
  logic       w_scr_push, w_scr_pop, w_scr_flush, w_scr_empty, w_scr_full, w_scr_drop;
  logic [7:0] w_man_dout, w_scr_dout;
  logic       w_idle, w_switch, w_pop, w_act_empty;
  logic [7:0] w_act_dout;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_switch    = w_idle && (src_sel != r_active);
  assign w_act_empty = (r_active == SRC_SCR) ? w_scr_empty : w_man_empty;
  assign w_act_dout  = (r_active == SRC_SCR) ? w_scr_dout  : w_man_dout;
  assign w_pop       = w_idle && !w_switch && !w_act_empty;

  // Only the source that currently owns the link may enqueue
  assign w_man_push  = man_valid && (r_active == SRC_MAN);
  assign w_scr_push  = scr_valid && (r_active == SRC_SCR);
  assign w_man_pop   = w_pop && (r_active == SRC_MAN);
  assign w_scr_pop   = w_pop && (r_active == SRC_SCR);

  // On a switch the outgoing owner's queue is discarded
  assign w_man_flush = w_switch && (r_active == SRC_MAN);
  assign w_scr_flush = w_switch && (r_active == SRC_SCR);

  assign w_man_drop  = w_man_push && w_man_full && !w_man_pop;
  assign w_scr_drop  = w_scr_push && w_scr_full && !w_scr_pop;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_man_fifo (
    .clock (clock),
    .reset (reset),
    .flush (w_man_flush),
    .push  (w_man_push),
    .din   (man_bits),
    .pop   (w_man_pop),
    .dout  (w_man_dout),
    .empty (w_man_empty),
    .full  (w_man_full)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_scr_fifo (
    .clock (clock),
    .reset (reset),
    .flush (w_scr_flush),
    .push  (w_scr_push),
    .din   (scr_bits),
    .pop   (w_scr_pop),
    .dout  (w_scr_dout),
    .empty (w_scr_empty),
    .full  (w_scr_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_active   <= SRC_MAN;
      r_gap_cnt  <= '0;
      r_tx_bits  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_man_ovf  <= 1'b0;
      r_scr_ovf  <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (w_man_drop) r_man_ovf <= 1'b1;
      if (w_scr_drop) r_scr_ovf <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_switch) begin
            r_active <= src_sel;
          end else if (w_pop) begin
            r_tx_bits  <= w_act_dout;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_gap_cnt <= GAP_LOAD;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_bits      = r_tx_bits;
  assign tx_valid     = r_tx_valid;
  assign busy         = r_busy;
  assign man_overflow = r_man_ovf;
  assign scr_overflow = r_scr_ovf;

endmodule
